// File: rtl/vector_length_if.sv
// Handshake bundle for vector_length: operand vector in, fixed-point magnitude out.
// Component 0 of op is x, 1 is y, 2 is z; each is a signed Q(W-F).F value.
`ifndef FIXED_W
`define FIXED_W 32
`endif
`ifndef FIXED_FRACTION_W
`define FIXED_FRACTION_W 16
`endif

interface vector_length_if;
  logic                          in_valid;
  logic                          in_ready;
  logic [2:0][`FIXED_W-1:0]      op;
  logic                          out_valid;
  logic                          out_ready;
  logic [`FIXED_W-1:0]           result;
  logic                          overflow;

  modport master (
    output in_valid, op, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, op, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/vector_length.sv
// Iterative vector magnitude |v| = sqrt(v.v): one cycle of dot product, then a
// restoring bit-serial square root, one result bit per cycle, MSB first.
`ifndef FIXED_W
`define FIXED_W 32
`endif
`ifndef FIXED_FRACTION_W
`define FIXED_FRACTION_W 16
`endif

module vector_length (
  input logic           clk,
  input logic           rst,
  vector_length_if.slave bus
);
  localparam int unsigned W  = `FIXED_W;
  localparam int unsigned F  = `FIXED_FRACTION_W;
  localparam int unsigned BW = $clog2(W);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StDot  = 2'd1;
  localparam logic [1:0] StSqrt = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [W-1:0] SatValue = {1'b0, {(W-1){1'b1}}};

  logic [1:0]          state_q, state_d;
  logic [2:0][W-1:0]   op_q, op_d;
  logic [W-1:0]        d_q, d_d;
  logic [W-1:0]        r_q, r_d;
  logic [BW-1:0]       b_q, b_d;
  logic [W-1:0]        result_q, result_d;
  logic                ovf_q, ovf_d;

  // Dot product op.op: exact sum of squares, then drop F fraction bits.
  logic [2*W-1:0]      sq [3];
  logic [2*W+1:0]      acc;
  logic [2*W+1:0]      acc_sh;
  logic                dot_ovf;

  always_comb begin
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      sq[i] = {{W{op_q[i][W-1]}}, op_q[i]} * {{W{op_q[i][W-1]}}, op_q[i]};
      acc   = acc + {2'b00, sq[i]};
    end
    acc_sh  = acc >> F;
    // Squares are non-negative, so any set bit at or above W-1 means the
    // value does not fit a positive W-bit fixed-point number (covers d<0 too).
    dot_ovf = |acc_sh[2*W+1:W-1];
  end

  // Square-root step: accept candidate bit when cand^2 <= d << F.
  logic [W-1:0]   cand;
  logic [2*W-1:0] cand_sq;
  logic [2*W-1:0] target;

  always_comb begin
    cand    = r_q | (W'(1) << b_q);
    cand_sq = {{W{1'b0}}, cand} * {{W{1'b0}}, cand};
    target  = {{W{1'b0}}, d_q} << F;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    d_d      = d_q;
    r_d      = r_q;
    b_d      = b_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          op_d    = bus.op;
          state_d = StDot;
        end
      end
      StDot: begin
        if (dot_ovf) begin
          result_d = SatValue;
          ovf_d    = 1'b1;
          state_d  = StDone;
        end else begin
          d_d     = acc_sh[W-1:0];
          r_d     = '0;
          b_d     = BW'(W - 2);
          state_d = StSqrt;
        end
      end
      StSqrt: begin
        if (cand_sq <= target) begin
          r_d = cand;
        end
        if (b_q == '0) begin
          result_d = r_d;
          ovf_d    = 1'b0;
          state_d  = StDone;
        end else begin
          b_d = b_q - 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      d_q      <= '0;
      r_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      d_q      <= d_d;
      r_q      <= r_d;
      b_q      <= b_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_vector_length.sv
// Scoreboard bench for vector_length: expected magnitudes come from an
// arithmetic sqrt model; a negedge observer checks latency, hold and results.
`ifndef FIXED_W
`define FIXED_W 32
`endif
`ifndef FIXED_FRACTION_W
`define FIXED_FRACTION_W 16
`endif

module tb_vector_length;
  localparam int W = `FIXED_W;
  localparam int F = `FIXED_FRACTION_W;
  localparam int NRAND = 800;

  typedef logic [2:0][W-1:0] vec_t;
  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_length_if vif ();
  vector_length dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  exp_t         q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           n_pop = 0;
  int           n_abort = 0;
  logic         armed = 1'b0;
  logic         chk_rst = 1'b0;
  logic         prev_ov = 1'b0;
  logic [W-1:0] held_res;
  logic         held_ovf;
  logic [W-1:0] last_res;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] fx(input int i);
    return W'(i) << F;
  endfunction

  function automatic vec_t vec(input int x, input int y, input int z);
    return {fx(z), fx(y), fx(x)};
  endfunction

  // Magnitude = largest r with r*r <= floor(sum(v_i^2) / 2^F) * 2^F.
  function automatic exp_t model(input vec_t v, input int c);
    exp_t         e;
    logic [127:0] sum;
    logic [127:0] dv;
    longint       m, t, r;
    sum = '0;
    for (int i = 0; i < 3; i++) begin
      m = longint'($signed(v[i]));
      if (m < 0) m = -m;
      sum = sum + 128'(m * m);
    end
    dv = sum >> F;
    e.acc_cyc = c;
    if (dv > 128'((64'd1 << (W - 1)) - 1)) begin
      e.ovf = 1'b1;
      e.res = {1'b0, {(W-1){1'b1}}};
    end else begin
      t = longint'(dv[63:0]) << F;
      r = longint'($sqrt(real'(t)));
      while (r * r > t) r--;
      while ((r + 1) * (r + 1) <= t) r++;
      e.ovf = 1'b0;
      e.res = r[W-1:0];
    end
    return e;
  endfunction

  // Observer: all bookkeeping in one place so in_ready vs. outstanding work is race-free.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      n_abort += q.size();
      q.delete();
      chk_rst = 1'b1;
      prev_ov = 1'b0;
      armed   = 1'b1;
    end else if (armed) begin
      if (chk_rst) begin
        check("reset_in_ready", vif.in_ready, 1);
        check("reset_out_valid", vif.out_valid, 0);
        check("reset_result", vif.result, 0);
        check("reset_overflow", vif.overflow, 0);
        chk_rst = 1'b0;
      end
      check("in_ready_vs_busy", vif.in_ready, q.size() == 0);
      if (vif.out_valid) begin
        check("out_valid_has_op", q.size() != 0, 1);
        if (q.size() != 0) begin
          if (!prev_ov) begin
            check("latency", cyc - q[0].acc_cyc, q[0].ovf ? 2 : W + 1);
            held_res = vif.result;
            held_ovf = vif.overflow;
          end else begin
            check("hold_result", vif.result, held_res);
            check("hold_overflow", vif.overflow, held_ovf);
          end
          if (vif.out_ready) begin
            check("result", vif.result, q[0].res);
            check("overflow", vif.overflow, q[0].ovf);
            last_res = vif.result;
            void'(q.pop_front());
            n_pop++;
          end
        end
      end
      prev_ov = vif.out_valid;
      if (vif.in_valid && vif.in_ready) begin
        e = model(vif.op, cyc);
        q.push_back(e);
      end
    end
  end

  task automatic send(input vec_t v);
    int k;
    vif.op       = v;
    vif.in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!vif.in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("send_accept", vif.in_ready, 1);
    @(posedge clk);
    #1;
    vif.in_valid = 1'b0;
    vif.op       = {$urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while ((q.size() != 0 || !vif.in_ready) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("drain", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_comp();
    case ($urandom_range(0, 3))
      0:       return W'($urandom());
      1:       return W'($urandom_range(0, 2 * (1 << 20)) - (1 << 20));
      2:       return W'($urandom_range(0, 2 * (1 << 23)) - (1 << 23));
      default: return '0;
    endcase
  endfunction

  logic rand_done = 1'b0;

  initial begin
    int k;
    int pop0;
    vif.in_valid  = 1'b0;
    vif.op        = '0;
    vif.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(vec(3, 4, 0));
    wait_idle();
    check("dir_3_4_0", last_res, 32'h0005_0000);

    send(vec(-1, 0, 0));
    send(vec(0, 0, 0));
    wait_idle();
    check("dir_zero", last_res, 32'h0000_0000);

    send(vec(1, 1, 0));
    wait_idle();
    check("dir_sqrt2", last_res, 32'h0001_6A09);

    send(vec(200, 200, 200));
    wait_idle();
    check("dir_sat", last_res, 32'h7FFF_FFFF);

    // Backpressure: result held for 10 cycles in DONE.
    vif.out_ready = 1'b0;
    send(vec(3, 4, 0));
    k = 0;
    while (!vif.out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("hold_reached_done", vif.out_valid, 1);
    repeat (10) @(posedge clk);
    #1 vif.out_ready = 1'b1;
    wait_idle();

    // Reset in the middle of SQRT aborts the op.
    send(vec(5, 12, 0));
    repeat (16) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(vec(5, 12, 0));
    wait_idle();
    check("after_reset_5_12", last_res, 32'h000D_0000);

    pop0 = n_pop;
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send({rand_comp(), rand_comp(), rand_comp()});
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 vif.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    vif.out_ready = 1'b1;
    wait_idle();
    check("random_count", n_pop - pop0, NRAND);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
